clock_divider_bank: RTL and testbench

- Parametrised, multi-channel successor to the fixed divide-by-218 speed clock.
- Each channel derives a one-cycle tick strobe and a 50%-duty toggled clock from CLOCK_50.
- Each channel has a runtime-programmable divisor that is double-buffered so period changes are glitch-free.
- Sits between the board clock and the pipeline stages (fetch/decode stepping, UART-rate timing).

---
 rtl/clock_divider_bank.sv | 89 ++++++++
 tb/tb_clock_divider_bank.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_divider_bank.sv
// clock_divider_bank: N_CH independent programmable clock dividers running on CLOCK_50.
// Each channel produces a one-cycle tick at every wrap and a 50%-duty toggled clock.
// Divisor updates are staged in a shadow register and only take effect at a safe
// point (clear, idle, or wrap), so a period change never produces a runt pulse.
module clock_divider_bank #(
  parameter int N_CH        = 2,
  parameter int CNT_W       = 10,
  parameter int SEL_W       = 1,
  parameter int DEFAULT_DIV = 217
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  input  logic [N_CH-1:0]       enable,
  input  logic [N_CH-1:0]       clr,
  input  logic                  div_wr,
  input  logic [SEL_W-1:0]      div_sel,
  input  logic [CNT_W-1:0]      div_data,
  output logic [N_CH-1:0]       tick,
  output logic [N_CH-1:0]       clk_out,
  output logic [N_CH-1:0]       pending,
  output logic [N_CH*CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] RESET_DIV = CNT_W'(DEFAULT_DIV);

  for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] active_q;
    logic [CNT_W-1:0] shadow_q;
    logic             tick_q;
    logic             clk_q;
    logic             pend_q;
    logic             wr_hit;
    logic             at_terminal;
    logic             apply_evt;

    // A select value with no matching channel simply never hits, so it is ignored.
    assign wr_hit      = div_wr && (div_sel == SEL_W'(ch));
    assign at_terminal = (cnt_q == active_q);
    assign apply_evt   = clr[ch] || !enable[ch] || at_terminal;

    // Counter, tick strobe and divided clock, in clear > idle > wrap > count priority.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset) begin
        cnt_q  <= '0;
        tick_q <= 1'b0;
        clk_q  <= 1'b0;
      end else if (clr[ch]) begin
        cnt_q  <= '0;
        tick_q <= 1'b0;
        clk_q  <= 1'b0;
      end else if (!enable[ch]) begin
        tick_q <= 1'b0;
      end else if (at_terminal) begin
        cnt_q  <= '0;
        tick_q <= 1'b1;
        clk_q  <= ~clk_q;
      end else begin
        cnt_q  <= cnt_q + CNT_W'(1);
        tick_q <= 1'b0;
      end
    end

    // Divisor double buffer; a write that lands on an apply point bypasses the shadow.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset) begin
        active_q <= RESET_DIV;
        shadow_q <= RESET_DIV;
        pend_q   <= 1'b0;
      end else if (wr_hit && apply_evt) begin
        active_q <= div_data;
        shadow_q <= div_data;
        pend_q   <= 1'b0;
      end else if (wr_hit) begin
        shadow_q <= div_data;
        pend_q   <= 1'b1;
      end else if (apply_evt && pend_q) begin
        active_q <= shadow_q;
        pend_q   <= 1'b0;
      end
    end

    assign tick[ch]                   = tick_q;
    assign clk_out[ch]                = clk_q;
    assign pending[ch]                = pend_q;
    assign count[ch*CNT_W +: CNT_W]   = cnt_q;
  end

endmodule

// File: tb/tb_clock_divider_bank.sv
// Testbench for clock_divider_bank: vector table, directed corner sequences and a
// randomized run, all compared against a per-channel behavioural model.
module tb_clock_divider_bank;

  localparam int N_CH  = 3;
  localparam int CNT_W = 10;
  localparam int SEL_W = 2;
  localparam int DEF   = 217;

  logic                  CLOCK_50 = 1'b0;
  logic                  reset;
  logic [N_CH-1:0]       enable;
  logic [N_CH-1:0]       clr;
  logic                  div_wr;
  logic [SEL_W-1:0]      div_sel;
  logic [CNT_W-1:0]      div_data;
  logic [N_CH-1:0]       tick;
  logic [N_CH-1:0]       clk_out;
  logic [N_CH-1:0]       pending;
  logic [N_CH*CNT_W-1:0] count;

  int checks = 0;
  int errors = 0;

  // Behavioural model state, one entry per channel.
  int m_count[N_CH];
  int m_active[N_CH];
  int m_shadow[N_CH];
  bit m_pending[N_CH];
  bit m_tick[N_CH];
  bit m_clk[N_CH];

  typedef struct {
    logic [N_CH-1:0]  en;
    logic [N_CH-1:0]  cl;
    logic             wr;
    logic [SEL_W-1:0] sel;
    logic [CNT_W-1:0] data;
    int               e_cnt;
    logic             e_tick;
    logic             e_clk;
    logic [N_CH-1:0]  e_pend;
  } vec_t;

  vec_t tbl[$];

  clock_divider_bank #(
    .N_CH(N_CH), .CNT_W(CNT_W), .SEL_W(SEL_W), .DEFAULT_DIV(DEF)
  ) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .enable(enable), .clr(clr),
    .div_wr(div_wr), .div_sel(div_sel), .div_data(div_data),
    .tick(tick), .clk_out(clk_out), .pending(pending), .count(count)
  );

  // 50 MHz-style free-running clock.
  always #5 CLOCK_50 = ~CLOCK_50;

  function automatic vec_t mk(input logic [N_CH-1:0] en, input logic [N_CH-1:0] cl,
                              input logic wr, input logic [SEL_W-1:0] sel,
                              input logic [CNT_W-1:0] data, input int e_cnt,
                              input logic e_tick, input logic e_clk,
                              input logic [N_CH-1:0] e_pend);
    vec_t v;
    v.en = en; v.cl = cl; v.wr = wr; v.sel = sel; v.data = data;
    v.e_cnt = e_cnt; v.e_tick = e_tick; v.e_clk = e_clk; v.e_pend = e_pend;
    return v;
  endfunction

  task automatic check_output(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  function automatic int dut_count(input int ch);
    return int'(count[ch*CNT_W +: CNT_W]);
  endfunction

  task automatic model_reset();
    for (int ch = 0; ch < N_CH; ch++) begin
      m_count[ch] = 0; m_active[ch] = DEF; m_shadow[ch] = DEF;
      m_pending[ch] = 0; m_tick[ch] = 0; m_clk[ch] = 0;
    end
  endtask

  // One rising edge of the specification's per-channel rules.
  task automatic model_step(input logic [N_CH-1:0] en, input logic [N_CH-1:0] cl,
                            input logic wr, input logic [SEL_W-1:0] sel,
                            input logic [CNT_W-1:0] data);
    for (int ch = 0; ch < N_CH; ch++) begin
      bit wrap = en[ch] && !cl[ch] && (m_count[ch] == m_active[ch]);
      bit safe = cl[ch] || !en[ch] || (m_count[ch] == m_active[ch]);
      bit mine = wr && (int'(sel) == ch);
      if (cl[ch]) begin
        m_count[ch] = 0; m_tick[ch] = 0; m_clk[ch] = 0;
      end else if (!en[ch]) begin
        m_tick[ch] = 0;
      end else if (wrap) begin
        m_count[ch] = 0; m_tick[ch] = 1; m_clk[ch] = !m_clk[ch];
      end else begin
        m_count[ch] = m_count[ch] + 1; m_tick[ch] = 0;
      end
      if (mine && safe) begin
        m_active[ch] = int'(data); m_shadow[ch] = int'(data); m_pending[ch] = 0;
      end else if (mine) begin
        m_shadow[ch] = int'(data); m_pending[ch] = 1;
      end else if (safe && m_pending[ch]) begin
        m_active[ch] = m_shadow[ch]; m_pending[ch] = 0;
      end
    end
  endtask

  function automatic logic [63:0] model_vec();
    logic [63:0] v = '0;
    for (int ch = 0; ch < N_CH; ch++) begin
      v[ch*CNT_W +: CNT_W]        = CNT_W'(m_count[ch]);
      v[N_CH*CNT_W + ch]          = m_tick[ch];
      v[N_CH*CNT_W + N_CH + ch]   = m_clk[ch];
      v[N_CH*CNT_W + 2*N_CH + ch] = m_pending[ch];
    end
    return v;
  endfunction

  // Drive one cycle of inputs at the falling edge, advance the model, compare after the rising edge.
  task automatic apply_stimulus(input logic [N_CH-1:0] en, input logic [N_CH-1:0] cl,
                                input logic wr, input logic [SEL_W-1:0] sel,
                                input logic [CNT_W-1:0] data);
    @(negedge CLOCK_50);
    enable = en; clr = cl; div_wr = wr; div_sel = sel; div_data = data;
    model_step(en, cl, wr, sel, data);
    @(posedge CLOCK_50);
    #1;
    check_output("model", 64'({pending, clk_out, tick, count}), model_vec());
  endtask

  task automatic idle_inputs();
    enable = '0; clr = '0; div_wr = 1'b0; div_sel = '0; div_data = '0;
  endtask

  task automatic do_reset();
    @(negedge CLOCK_50);
    idle_inputs();
    reset = 1'b0;
    model_reset();
    repeat (2) @(negedge CLOCK_50);
    reset = 1'b1;
  endtask

  // Run enabled cycles until the channel ticks; returns the cycle count (bounded).
  task automatic wait_tick(input int ch, input logic [N_CH-1:0] en, input int max_cycles,
                           output int n);
    n = 0;
    do begin
      apply_stimulus(en, '0, 1'b0, '0, '0);
      n++;
    end while (!tick[ch] && n < max_cycles);
  endtask

  initial begin
    int n;
    logic exp_clk;

    reset = 1'b1;
    idle_inputs();
    #2 reset = 1'b0;
    model_reset();
    #1;
    check_output("reset_outputs", 64'({pending, clk_out, tick, count}), 64'(0));
    repeat (2) @(negedge CLOCK_50);
    reset = 1'b1;

    // Vector table for channel 0: bypass writes, pending apply, divisor 0, bad select, clr collision.
    tbl.push_back(mk(3'b000, 3'b000, 1, 2'd0, 10'd2,  0, 0, 0, 3'b000));
    tbl.push_back(mk(3'b001, 3'b000, 0, 2'd0, 10'd0,  1, 0, 0, 3'b000));
    tbl.push_back(mk(3'b001, 3'b000, 0, 2'd0, 10'd0,  2, 0, 0, 3'b000));
    tbl.push_back(mk(3'b001, 3'b000, 0, 2'd0, 10'd0,  0, 1, 1, 3'b000));
    tbl.push_back(mk(3'b001, 3'b000, 1, 2'd0, 10'd0,  1, 0, 1, 3'b001));
    tbl.push_back(mk(3'b001, 3'b000, 0, 2'd0, 10'd0,  2, 0, 1, 3'b001));
    tbl.push_back(mk(3'b001, 3'b000, 0, 2'd0, 10'd0,  0, 1, 0, 3'b000));
    tbl.push_back(mk(3'b001, 3'b000, 0, 2'd0, 10'd0,  0, 1, 1, 3'b000));
    tbl.push_back(mk(3'b001, 3'b000, 0, 2'd0, 10'd0,  0, 1, 0, 3'b000));
    tbl.push_back(mk(3'b001, 3'b000, 1, 2'd3, 10'd5,  0, 1, 1, 3'b000));
    tbl.push_back(mk(3'b001, 3'b001, 1, 2'd0, 10'd9,  0, 0, 0, 3'b000));
    tbl.push_back(mk(3'b000, 3'b000, 0, 2'd0, 10'd0,  0, 0, 0, 3'b000));
    tbl.push_back(mk(3'b001, 3'b000, 0, 2'd0, 10'd0,  1, 0, 0, 3'b000));
    tbl.push_back(mk(3'b001, 3'b000, 1, 2'd1, 10'd4,  2, 0, 0, 3'b000));
    tbl.push_back(mk(3'b010, 3'b000, 0, 2'd0, 10'd0,  2, 0, 0, 3'b000));
    tbl.push_back(mk(3'b001, 3'b000, 1, 2'd0, 10'd20, 3, 0, 0, 3'b001));
    tbl.push_back(mk(3'b001, 3'b000, 1, 2'd0, 10'd1,  4, 0, 0, 3'b001));
    for (int k = 5; k <= 9; k++)
      tbl.push_back(mk(3'b001, 3'b000, 0, 2'd0, 10'd0, k, 0, 0, 3'b001));
    tbl.push_back(mk(3'b001, 3'b000, 0, 2'd0, 10'd0,  0, 1, 1, 3'b000));
    tbl.push_back(mk(3'b001, 3'b000, 0, 2'd0, 10'd0,  1, 0, 1, 3'b000));
    tbl.push_back(mk(3'b001, 3'b000, 0, 2'd0, 10'd0,  0, 1, 0, 3'b000));

    foreach (tbl[i]) begin
      apply_stimulus(tbl[i].en, tbl[i].cl, tbl[i].wr, tbl[i].sel, tbl[i].data);
      check_output($sformatf("vec%0d", i),
                   64'({pending, clk_out[0], tick[0], count[CNT_W-1:0]}),
                   64'({tbl[i].e_pend, tbl[i].e_clk, tbl[i].e_tick, CNT_W'(tbl[i].e_cnt)}));
    end

    // Default divisor: first tick 218 cycles after enable, then every 218, clk_out toggling.
    do_reset();
    wait_tick(0, 3'b001, 400, n);
    check_output("default_first_tick", 64'(n), 64'(218));
    check_output("default_clk_high", 64'(clk_out[0]), 64'(1));
    wait_tick(0, 3'b001, 400, n);
    check_output("default_second_tick", 64'(n), 64'(218));
    check_output("default_clk_low", 64'(clk_out[0]), 64'(0));
    check_output("idle_ch1_count", 64'(dut_count(1)), 64'(0));

    // Mid-count write on channel 1 waits for the wrap, then ticks every 4 cycles.
    do_reset();
    repeat (100) apply_stimulus(3'b010, '0, 1'b0, '0, '0);
    check_output("ch1_count100", 64'(dut_count(1)), 64'(100));
    apply_stimulus(3'b010, '0, 1'b1, 2'd1, 10'd3);
    check_output("ch1_pending_set", 64'(pending), 64'(3'b010));
    wait_tick(1, 3'b010, 400, n);
    check_output("ch1_old_period_tick", 64'(n), 64'(117));
    check_output("ch1_pending_clear", 64'(pending[1]), 64'(0));
    for (int k = 1; k <= 3; k++) begin
      apply_stimulus(3'b010, '0, 1'b0, '0, '0);
      check_output($sformatf("ch1_seq%0d", k), 64'(dut_count(1)), 64'(k));
    end
    wait_tick(1, 3'b010, 20, n);
    check_output("ch1_new_period_tick", 64'(n), 64'(1));
    wait_tick(1, 3'b010, 20, n);
    check_output("ch1_new_period", 64'(n), 64'(4));

    // Divisor 0: tick held high, count at 0, clk_out toggling every cycle.
    do_reset();
    apply_stimulus('0, '0, 1'b1, 2'd0, 10'd0);
    exp_clk = 1'b0;
    for (int k = 0; k < 6; k++) begin
      apply_stimulus(3'b001, '0, 1'b0, '0, '0);
      exp_clk = ~exp_clk;
      check_output($sformatf("div0_cycle%0d", k),
                   64'({clk_out[0], tick[0], count[CNT_W-1:0]}),
                   64'({exp_clk, 1'b1, CNT_W'(0)}));
    end

    // Enable dropped at count 50: hold, resume at 51, wrap delayed by the idle cycles.
    do_reset();
    repeat (50) apply_stimulus(3'b001, '0, 1'b0, '0, '0);
    repeat (5) apply_stimulus(3'b000, '0, 1'b0, '0, '0);
    check_output("hold_count", 64'({tick[0], count[CNT_W-1:0]}), 64'({1'b0, CNT_W'(50)}));
    apply_stimulus(3'b001, '0, 1'b0, '0, '0);
    check_output("resume_count", 64'(dut_count(0)), 64'(51));
    wait_tick(0, 3'b001, 400, n);
    check_output("resume_wrap", 64'(n), 64'(167));

    // clr at terminal count with a colliding write: bypass to 9, next tick 10 cycles later.
    do_reset();
    apply_stimulus('0, '0, 1'b1, 2'd0, 10'd3);
    repeat (3) apply_stimulus(3'b001, '0, 1'b0, '0, '0);
    check_output("clr_at_terminal_pre", 64'(dut_count(0)), 64'(3));
    apply_stimulus(3'b001, 3'b001, 1'b1, 2'd0, 10'd9);
    check_output("clr_collision",
                 64'({pending[0], clk_out[0], tick[0], count[CNT_W-1:0]}), 64'(0));
    wait_tick(0, 3'b001, 40, n);
    check_output("clr_collision_period", 64'(n), 64'(10));

    // Largest divisor runs the full counter range and wraps through terminal count.
    do_reset();
    apply_stimulus('0, '0, 1'b1, 2'd2, 10'd1023);
    wait_tick(2, 3'b100, 1100, n);
    check_output("max_div_period", 64'(n), 64'(1024));

    // Asynchronous reset between edges discards pending writes and restores the default.
    do_reset();
    repeat (30) apply_stimulus(3'b111, '0, 1'b0, '0, '0);
    apply_stimulus(3'b111, '0, 1'b1, 2'd2, 10'd5);
    check_output("async_pre_pending", 64'(pending), 64'(3'b100));
    @(posedge CLOCK_50);
    #3;
    idle_inputs();
    reset = 1'b0;
    model_reset();
    #1;
    check_output("async_reset_outputs", 64'({pending, clk_out, tick, count}), 64'(0));
    @(negedge CLOCK_50);
    reset = 1'b1;
    wait_tick(2, 3'b100, 400, n);
    check_output("async_default_restored", 64'(n), 64'(218));

    // Randomized run against the model, small divisors so wraps are frequent.
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      logic [N_CH-1:0] en;
      logic [N_CH-1:0] cl;
      for (int ch = 0; ch < N_CH; ch++) begin
        en[ch] = ($urandom_range(0, 7) != 0);
        cl[ch] = ($urandom_range(0, 31) == 0);
      end
      apply_stimulus(en, cl, ($urandom_range(0, 7) == 0), SEL_W'($urandom_range(0, 3)),
                     CNT_W'($urandom_range(0, 12)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
